// File: rtl/prog_loader_pkg.sv
// Shared CPU package: loader FSM state encodings and program word geometry.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler: byte counter plus placement register.
module word_assembler
  import prog_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             take,
  input  logic [7:0]       byte_in,
  output logic             full,
  output logic [WIDTH-1:0] word_next
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word;

  // word_next already contains the byte being accepted, so the last byte lands in the write data
  always_comb begin
    word_next = word;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (cnt == CNT_W'(i)) word_next[i*8 +: 8] = byte_in;
    end
  end

  assign full = take && (cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (take) begin
      cnt  <= cnt + CNT_W'(1);
      word <= word_next;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: collects bytes into words, writes program memory, then releases the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADD_WIDTH = 8,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_rst,
  output logic                 done,
  output logic [ADD_WIDTH:0]   word_count
);

  state_t               state, next_state;
  logic                 load_q;
  logic [ADD_WIDTH-1:0] addr;
  logic                 take, full;
  logic [WIDTH-1:0]     word_next;
  logic                 ready_d, wen_d, cpu_rst_d, done_d;

  assign take = byte_valid && byte_ready;

  word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != COLLECT),
    .take      (take),
    .byte_in   (byte_in),
    .full      (full),
    .word_next (word_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Reload from DONE needs a fresh load_en rise, so a held request cannot loop over a full memory
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_en) next_state = COLLECT;
      COLLECT: if (!load_en) next_state = DONE;
               else if (full) next_state = WRITE;
      WRITE:   if (!load_en || addr == ADD_WIDTH'(DEPTH - 1)) next_state = DONE;
               else next_state = COLLECT;
      DONE:    if (load_en && !load_q) next_state = COLLECT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_d   = (next_state == COLLECT);
    wen_d     = (next_state == WRITE);
    cpu_rst_d = (next_state != DONE);
    done_d    = (next_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q     <= 1'b0;
      addr       <= '0;
      byte_ready <= 1'b0;
      mem_wen    <= 1'b0;
      mem_add    <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      load_q     <= load_en;
      byte_ready <= ready_d;
      mem_wen    <= wen_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      if ((state == IDLE || state == DONE) && next_state == COLLECT) begin
        addr       <= '0;
        word_count <= '0;
      end
      if (state == COLLECT && next_state == WRITE) begin
        mem_add   <= addr;
        mem_wdata <= word_next;
      end
      if (state == WRITE) begin
        addr       <= addr + ADD_WIDTH'(1);
        word_count <= word_count + (ADD_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus, popped by a write monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_wen, cpu_rst, done;
  logic [7:0]  mem_add;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  typedef struct packed {
    logic [7:0]  add;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  writes = 0;

  prog_loader #(.WIDTH(32), .ADD_WIDTH(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wen    (mem_wen),
    .mem_add    (mem_add),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wen) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual add=0x%0h data=0x%0h required=none", mem_add, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_add", 64'(mem_add), 64'(e.add));
        check("write_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // While the loader is busy, junk with byte_valid=1 is shown; it must never be taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      byte_in = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("byte_ready_timeout", 64'(byte_ready), 64'd1);
    end else begin
      byte_in = b;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] add, input logic [31:0] w, input int gap_max);
    logic [31:0] v;
    v = w;
    exp_q.push_back('{add: add, data: w});
    for (int k = 0; k < 4; k++) begin
      if (gap_max > 0) gap(int'($urandom_range(0, gap_max)));
      send_byte(v[k*8 +: 8]);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    int w0;
    logic [7:0] i8;

    // Reset state, asserted asynchronously before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word 13,00,10,00 then drop load_en while collecting
    load_en = 1'b1;
    send_word(8'd0, 32'h0010_0013, 0);
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    wait_done("t1_done");
    @(negedge clk);
    check("t1_cpu_rst", 64'(cpu_rst), 64'd0);
    check("t1_word_count", 64'(word_count), 64'd1);
    check("t1_mem_add_hold", 64'(mem_add), 64'd0);
    check("t1_mem_wdata_hold", 64'(mem_wdata), 64'h0010_0013);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Full memory: 256 words, stops after address 255 even with load_en held
    load_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      send_word(i8, {i8 + 8'd1, ~i8, i8 ^ 8'h5A, i8}, 0);
    end
    wait_done("t2_done");
    check("t2_word_count", 64'(word_count), 64'd256);
    check("t2_last_add", 64'(mem_add), 64'd255);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_ready_after_full", 64'(byte_ready), 64'd0);
      check("t2_done_held", 64'(done), 64'd1);
    end
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    load_en = 1'b0;
    @(negedge clk);

    // Six bytes then drop: two trailing bytes discarded
    w0 = writes;
    load_en = 1'b1;
    send_word(8'd0, 32'h4433_2211, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    load_en = 1'b0;
    wait_done("t3_done");
    repeat (3) @(negedge clk);
    check("t3_word_count", 64'(word_count), 64'd1);
    check("t3_write_count", 64'(writes - w0), 64'd1);
    check("t3_mem_wdata_hold", 64'(mem_wdata), 64'h4433_2211);

    // Random gaps and busy-time junk; drop load_en during the last WRITE
    load_en = 1'b1;
    send_word(8'd0, 32'hA1B2_C3D4, 3);
    send_word(8'd1, 32'h0BAD_F00D, 3);
    send_word(8'd2, 32'h1234_5678, 3);
    load_en = 1'b0;
    wait_done("t4_done");
    @(negedge clk);
    check("t4_word_count", 64'(word_count), 64'd3);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset after two bytes of the third word
    load_en = 1'b1;
    send_word(8'd0, 32'h0000_00AA, 0);
    send_word(8'd1, 32'h0000_00BB, 0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    #2 rst = 1'b1;
    #1;
    check("t5_byte_ready", 64'(byte_ready), 64'd0);
    check("t5_mem_wen", 64'(mem_wen), 64'd0);
    check("t5_mem_add", 64'(mem_add), 64'd0);
    check("t5_mem_wdata", 64'(mem_wdata), 64'd0);
    check("t5_word_count", 64'(word_count), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_cpu_rst", 64'(cpu_rst), 64'd1);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idle_cpu_rst", 64'(cpu_rst), 64'd1);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reach DONE with no writes, then reload one word from DONE
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    wait_done("t6_first_done");
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    check("t6_cpu_rst_reload", 64'(cpu_rst), 64'd1);
    check("t6_done_reload", 64'(done), 64'd0);
    check("t6_ready_reload", 64'(byte_ready), 64'd1);
    send_word(8'd0, 32'hDEAD_BEEF, 1);
    check("t6_cpu_rst_write", 64'(cpu_rst), 64'd1);
    load_en = 1'b0;
    wait_done("t6_done");
    @(negedge clk);
    check("t6_word_count", 64'(word_count), 64'd1);
    check("t6_cpu_rst_run", 64'(cpu_rst), 64'd0);
    check("t6_mem_add", 64'(mem_add), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning instruction word width in bits (fixed at 4 bytes).
REQ-002 The block SHALL have parameter ADD_WIDTH, default 8, meaning program memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning program memory words (2**ADD_WIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-006 The block SHALL have port load_en, input, 1 bit, a level request to (re)load program memory.
REQ-007 The block SHALL have port byte_in, input, 8 bits, a serial program byte.
REQ-008 The block SHALL have port byte_valid, input, 1 bit, meaning byte_in is valid.
REQ-009 The block SHALL have port byte_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-010 The block SHALL have port mem_wen, output, 1 bit, the program memory write strobe.
REQ-011 The block SHALL have port mem_add, output, ADD_WIDTH bits, the program memory write address.
REQ-012 The block SHALL have port mem_wdata, output, WIDTH bits, the program memory write data.
REQ-013 The block SHALL have port cpu_rst, output, 1 bit, holding the pipelined CPU in reset while high.
REQ-014 The block SHALL have port done, output, 1 bit, meaning a load has completed and the CPU runs.
REQ-015 The block SHALL have port word_count, output, ADD_WIDTH+1 bits, counting words written in the last/current load.

Function
REQ-016 States SHALL be IDLE, COLLECT, WRITE, DONE; all outputs SHALL be registered.
REQ-017 A byte transfer SHALL occur only on a rising edge with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in COLLECT.
REQ-018 Bytes SHALL be assembled little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-019 IDLE -> COLLECT when load_en=1; address counter and word_count SHALL be cleared on that entry.
REQ-020 COLLECT -> WRITE on the edge accepting the 4th byte; mem_wen SHALL be 1 for exactly one cycle in WRITE, with mem_add=current address and mem_wdata=assembled word.
REQ-021 The 4th-byte edge to the mem_wen=1 cycle latency SHALL be 1 clock; byte_ready SHALL be 0 during WRITE.
REQ-022 WRITE SHALL increment address and word_count; WRITE -> DONE if the written address was DEPTH-1 (memory full, no wrap), else WRITE -> COLLECT.
REQ-023 COLLECT with load_en=0 SHALL go to DONE; a partially assembled word (1-3 bytes) SHALL be discarded, with no write.
REQ-024 load_en falling during WRITE SHALL let the write complete, then go to DONE.
REQ-025 cpu_rst SHALL be 1 in IDLE, COLLECT and WRITE, and 0 only in DONE; done SHALL equal (state==DONE).
REQ-026 DONE -> COLLECT when load_en=1 (reload from address 0; cpu_rst re-asserts next cycle).
REQ-027 Outside WRITE, mem_wen SHALL be 0; mem_add and mem_wdata SHALL hold their last values.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, byte_ready=0, mem_wen=0, mem_add=0, mem_wdata=0, word_count=0, done=0, cpu_rst=1, byte counter=0.
REQ-029 rst mid-load SHALL abort with no further memory write; already written words remain in memory.

Structure
REQ-030 State encodings and the byte-per-word constant (4) SHALL live in the shared CPU package/include used by the pipeline stages.
REQ-031 Byte assembly (2-bit byte counter plus shift/placement register) SHALL be one sub-module, word_assembler; FSM and address counter stay in prog_loader.

Verification
REQ-032 Load bytes 13,00,10,00 then drop load_en -> one write mem_add=0, mem_wdata=0x00100013; done=1, cpu_rst=0, word_count=1.
REQ-033 Stream 1024 bytes with load_en held -> 256 writes at addresses 0..255, DONE after address 255, byte_ready=0 thereafter, word_count=256.
REQ-034 Send 6 bytes then drop load_en -> exactly 1 write; 2 trailing bytes discarded; word_count=1.
REQ-035 Toggle byte_valid randomly with gaps; hold byte_in changing while byte_ready=0 -> only handshaken bytes appear, correct word order.
REQ-036 Assert rst after 2 bytes of word 3 -> all outputs at reset values asynchronously; no write to address 2.
REQ-037 From DONE, re-assert load_en and load 1 word 0xDEADBEEF -> cpu_rst=1 during load, write at mem_add=0, word_count=1.
